jtcps1_pal_loader: RTL and testbench

- Sequences palette refresh for the colour mixer: copies palette words from video RAM into the 4096×16 palette RAM that feeds the brightness/RGB stage.
- A CPU write to the palette-base register arms a copy. The copy starts at the next vertical blank, reads VRAM through a request/ok port and writes each word into the palette write port.
- Six 512-entry pages, individually enabled by the CPS-B palette-control mask.

---
 rtl/jtcps1_pal_loader_pkg.sv | 19 +
 rtl/jtcps1_pal_loader_if.sv | 25 ++
 rtl/jtcps1_pal_pagesel.sv | 28 ++
 rtl/jtcps1_pal_loader.sv | 148 ++++++++++++++
 tb/tb_jtcps1_pal_loader.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtcps1_pal_loader_pkg.sv
// Shared definitions for the CPS1 palette loader.
// Contents: page geometry, source-address shift and the loader state encoding.
package jtcps1_pal_pkg;

    localparam int PAGES          = 6;   // 512-word palette pages
    localparam int PAGE_W         = 9;   // log2 of words per page
    localparam int PAL_BASE_SHIFT = 7;   // pal_base is a 128-word aligned VRAM address
    localparam int SRC_W          = 23;  // VRAM word address width
    localparam int PAGE_SEL_W     = 3;   // page index width inside the 4096-entry palette

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_REQ,
        ST_WRITE,
        ST_FINISH
    } state_t;

endpackage

// File: rtl/jtcps1_pal_loader_if.sv
// Memory-side bus of the palette loader: VRAM read port plus palette RAM write port.
// master : loader side (drives vram_addr/vram_req and the palette write port)
// slave  : memory side (returns vram_ok/vram_data, sinks the palette writes)
interface jtcps1_pal_loader_if;
    import jtcps1_pal_pkg::*;

    logic [SRC_W-1:0]              vram_addr;
    logic                          vram_req;
    logic                          vram_ok;
    logic [15:0]                   vram_data;
    logic                          pal_we;
    logic [PAGE_SEL_W+PAGE_W-1:0]  pal_waddr;
    logic [15:0]                   pal_wdata;

    modport master (
        output vram_addr, vram_req, pal_we, pal_waddr, pal_wdata,
        input  vram_ok, vram_data
    );

    modport slave (
        input  vram_addr, vram_req, pal_we, pal_waddr, pal_wdata,
        output vram_ok, vram_data
    );

endinterface

// File: rtl/jtcps1_pal_pagesel.sv
// Next-enabled-page finder (purely combinational).
// mask       : page enable mask, bit n = page n
// cur        : page currently being copied
// from_start : search from page 0 instead of above cur
// next/valid : lowest qualifying enabled page, valid=0 when none remains
module jtcps1_pal_pagesel
    import jtcps1_pal_pkg::*;
(
    input  logic [PAGES-1:0]      mask,
    input  logic [PAGE_SEL_W-1:0] cur,
    input  logic                  from_start,
    output logic [PAGE_SEL_W-1:0] next,
    output logic                  valid
);

    // Scan downwards so the lowest qualifying page is the last one assigned.
    always_comb begin
        next  = '0;
        valid = 1'b0;
        for (int p = PAGES - 1; p >= 0; p--) begin
            if (mask[p] && (from_start || (PAGE_SEL_W'(p) > cur))) begin
                next  = PAGE_SEL_W'(p);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jtcps1_pal_loader.sv
// Palette refresh sequencer: copies enabled 512-word pages from VRAM into the
// palette RAM at the first VB rising edge after the palette-base register is written.
// Ports: clk, rst (sync, active high), VB, pal_copy strobe, pal_base, pal_page_en,
//        bus (VRAM read + palette write, master side), busy, done.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// ST_IDLE   | waiting for VB rising edge with a pending copy
// ST_START  | latch base/mask, clear pending, pick first enabled page
// ST_REQ    | VRAM read requested at src, waiting for vram_ok
// ST_WRITE  | write captured word to palette, advance src/idx/page
// ST_FINISH | one-cycle done pulse
module jtcps1_pal_loader
    import jtcps1_pal_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                VB,
    input  logic                pal_copy,
    input  logic [15:0]         pal_base,
    input  logic [PAGES-1:0]    pal_page_en,
    jtcps1_pal_loader_if.master bus,
    output logic                busy,
    output logic                done
);

    state_t                  state_q, state_d;
    logic                    vb_d1_q, vb_d1_d;
    logic                    pending_q, pending_d;
    logic [PAGES-1:0]        mask_q, mask_d;
    logic [SRC_W-1:0]        src_q, src_d;
    logic [PAGE_SEL_W-1:0]   page_q, page_d;
    logic [PAGE_W-1:0]       idx_q, idx_d;
    logic [15:0]             data_q, data_d;

    logic                    vb_rise;
    logic [PAGES-1:0]        ps_mask;
    logic                    ps_from_start;
    logic [PAGE_SEL_W-1:0]   ps_next;
    logic                    ps_valid;

    // START searches the live mask (it is being latched that same cycle);
    // later page steps use the latched copy.
    assign ps_from_start = (state_q == ST_START);
    assign ps_mask       = ps_from_start ? pal_page_en : mask_q;

    jtcps1_pal_pagesel u_pagesel (
        .mask       (ps_mask),
        .cur        (page_q),
        .from_start (ps_from_start),
        .next       (ps_next),
        .valid      (ps_valid)
    );

    assign vb_rise = VB & ~vb_d1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            vb_d1_q   <= 1'b0;
            pending_q <= 1'b0;
            mask_q    <= '0;
            src_q     <= '0;
            page_q    <= '0;
            idx_q     <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            vb_d1_q   <= vb_d1_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            src_q     <= src_d;
            page_q    <= page_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        vb_d1_d   = VB;
        pending_d = pending_q | pal_copy;
        mask_d    = mask_q;
        src_d     = src_q;
        page_d    = page_q;
        idx_d     = idx_q;
        data_d    = data_q;
        case (state_q)
            ST_IDLE: begin
                // A strobe coincident with the VB edge counts as pending.
                if (vb_rise && (pending_q || pal_copy)) state_d = ST_START;
            end
            ST_START: begin
                // A strobe during START re-arms for the following frame.
                pending_d = pal_copy;
                mask_d    = pal_page_en;
                src_d     = {pal_base, {PAL_BASE_SHIFT{1'b0}}};
                idx_d     = '0;
                page_d    = ps_next;
                state_d   = ps_valid ? ST_REQ : ST_FINISH;
            end
            ST_REQ: begin
                if (bus.vram_ok) begin
                    data_d  = bus.vram_data;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                src_d   = src_q + 1'b1;
                idx_d   = idx_q + 1'b1;
                state_d = ST_REQ;
                if (idx_q == '1) begin
                    if (ps_valid) page_d  = ps_next;
                    else          state_d = ST_FINISH;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.vram_req  = 1'b0;
        bus.vram_addr = '0;
        bus.pal_we    = 1'b0;
        bus.pal_waddr = '0;
        bus.pal_wdata = '0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state_q)
            ST_START: busy = 1'b1;
            ST_REQ: begin
                busy          = 1'b1;
                bus.vram_req  = 1'b1;
                bus.vram_addr = src_q;
            end
            ST_WRITE: begin
                busy          = 1'b1;
                bus.pal_we    = 1'b1;
                bus.pal_waddr = {page_q, idx_q};
                bus.pal_wdata = data_q;
            end
            ST_FINISH: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_jtcps1_pal_loader.sv
module tb_jtcps1_pal_loader;
    import jtcps1_pal_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        VB = 1'b0;
    logic        pal_copy = 1'b0;
    logic [15:0] pal_base = '0;
    logic [5:0]  pal_page_en = '0;
    logic        busy, done;

    jtcps1_pal_loader_if bus();

    jtcps1_pal_loader dut (
        .clk         (clk),
        .rst         (rst),
        .VB          (VB),
        .pal_copy    (pal_copy),
        .pal_base    (pal_base),
        .pal_page_en (pal_page_en),
        .bus         (bus),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] wa;
        logic [15:0] wd;
    } wr_t;

    typedef struct {
        logic [15:0] base;
        logic [5:0]  mask;
        int          dly;
        int          n;
        logic [11:0] fwa;
        logic [15:0] fwd;
        logic [11:0] lwa;
        logic [15:0] lwd;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    int          delay = 0;
    int          stray_en = 0;
    logic [15:0] salt = '0;
    wr_t         exp_q[$];
    int          wr_cnt, done_cnt, busy_cyc, req_cyc;
    logic [11:0] first_wa, last_wa;
    logic [15:0] first_wd, last_wd;

    function automatic logic [15:0] vdata(logic [22:0] a);
        return a[15:0] ^ salt;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_stats();
        wr_cnt = 0; done_cnt = 0; busy_cyc = 0; req_cyc = 0;
        first_wa = '0; last_wa = '0; first_wd = '0; last_wd = '0;
    endtask

    // Reference: every enabled page, in ascending order, receives 512
    // consecutive VRAM words starting at base*128; disabled pages consume none.
    task automatic model_copy(logic [15:0] base, logic [5:0] mask);
        logic [22:0] src;
        wr_t w;
        src = {base, 7'd0};
        for (int p = 0; p < 6; p++) begin
            if (mask[p]) begin
                for (int i = 0; i < 512; i++) begin
                    w.wa = 12'(p * 512 + i);
                    w.wd = vdata(src);
                    exp_q.push_back(w);
                    src = src + 23'd1;
                end
            end
        end
    endtask

    task automatic strobe_copy();
        pal_copy = 1'b1;
        tick(1);
        pal_copy = 1'b0;
    endtask

    task automatic vb_pulse();
        VB = 1'b1;
        tick(4);
        VB = 1'b0;
        tick(1);
    endtask

    task automatic wait_done(string name);
        int k = 0;
        while (done_cnt == 0 && k < 20000) begin
            tick(1);
            k++;
        end
        tests++;
        if (done_cnt == 0) begin
            fails++;
            $display("FAIL %s: done not seen within %0d cycles", name, k);
        end
        tick(3);
    endtask

    task automatic run_copy(string name, logic [15:0] base, logic [5:0] mask, int d);
        delay       = d;
        pal_base    = base;
        pal_page_en = mask;
        clr_stats();
        strobe_copy();
        model_copy(base, mask);
        vb_pulse();
        wait_done(name);
        chk({name, "_drained"}, exp_q.size(), 0);
        chk({name, "_done_cnt"}, done_cnt, 1);
    endtask

    // VRAM model: answers after `delay` waiting cycles, optionally throws in
    // stray vram_ok pulses while no request is outstanding.
    initial begin
        logic [22:0] held_addr;
        int          cnt;
        logic        prev_req;
        held_addr = '0; cnt = 0; prev_req = 1'b0;
        bus.vram_ok = 1'b0;
        bus.vram_data = '0;
        forever begin
            @(negedge clk);
            if (bus.vram_req) begin
                if (prev_req) chk("vram_addr_stable", 32'(bus.vram_addr), 32'(held_addr));
                held_addr = bus.vram_addr;
                prev_req  = 1'b1;
                if (cnt >= delay) begin
                    bus.vram_ok   = 1'b1;
                    bus.vram_data = vdata(bus.vram_addr);
                end else begin
                    bus.vram_ok = 1'b0;
                    cnt++;
                end
            end else begin
                cnt      = 0;
                prev_req = 1'b0;
                bus.vram_ok   = (stray_en != 0) && ($urandom_range(0, 7) == 0);
                bus.vram_data = 16'($urandom);
            end
        end
    end

    always @(negedge clk) begin
        wr_t e;
        if (done)         done_cnt++;
        if (busy)         busy_cyc++;
        if (bus.vram_req) req_cyc++;
        if (bus.pal_we) begin
            wr_cnt++;
            if (wr_cnt == 1) begin
                first_wa = bus.pal_waddr;
                first_wd = bus.pal_wdata;
            end
            last_wa = bus.pal_waddr;
            last_wd = bus.pal_wdata;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: waddr %0h data %0h, none expected",
                         bus.pal_waddr, bus.pal_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("pal_waddr", 32'(bus.pal_waddr), 32'(e.wa));
                chk("pal_wdata", 32'(bus.pal_wdata), 32'(e.wd));
            end
        end
    end

    initial begin
        vec_t vt[4];
        int   k;
        vt[0] = '{16'h9000, 6'b111111, 0, 3072, 12'h000, 16'h0000, 12'hBFF, 16'h0BFF};
        vt[1] = '{16'h0001, 6'b000101, 0, 1024, 12'h000, 16'h0080, 12'h5FF, 16'h047F};
        vt[2] = '{16'hFFFF, 6'b100000, 1,  512, 12'hA00, 16'hFF80, 12'hBFF, 16'h017F};
        vt[3] = '{16'h1234, 6'b010010, 0, 1024, 12'h200, 16'h1A00, 12'h9FF, 16'h1DFF};
        clr_stats();

        tick(3);
        @(negedge clk);
        chk("rst_vram_req",  32'(bus.vram_req), 0);
        chk("rst_vram_addr", 32'(bus.vram_addr), 0);
        chk("rst_pal_we",    32'(bus.pal_we), 0);
        chk("rst_pal_waddr", 32'(bus.pal_waddr), 0);
        chk("rst_pal_wdata", 32'(bus.pal_wdata), 0);
        chk("rst_busy",      32'(busy), 0);
        chk("rst_done",      32'(done), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick(2);

        // VB edge without a pending copy does nothing
        clr_stats();
        vb_pulse();
        tick(3);
        chk("no_pending_busy", busy_cyc, 0);

        for (int i = 0; i < 4; i++) begin
            salt = '0;
            run_copy($sformatf("vec%0d", i), vt[i].base, vt[i].mask, vt[i].dly);
            chk($sformatf("vec%0d_writes", i),  wr_cnt, vt[i].n);
            chk($sformatf("vec%0d_first_wa", i), 32'(first_wa), 32'(vt[i].fwa));
            chk($sformatf("vec%0d_first_wd", i), 32'(first_wd), 32'(vt[i].fwd));
            chk($sformatf("vec%0d_last_wa", i),  32'(last_wa), 32'(vt[i].lwa));
            chk($sformatf("vec%0d_last_wd", i),  32'(last_wd), 32'(vt[i].lwd));
        end

        // zero mask: START then FINISH, no VRAM traffic
        delay = 0;
        clr_stats();
        pal_page_en = 6'b000000;
        pal_base    = 16'h1111;
        strobe_copy();
        VB = 1'b1;
        tick(3);
        chk("zero_done", done_cnt, 1);
        chk("zero_busy_cycles", busy_cyc, 1);
        chk("zero_req_cycles", req_cyc, 0);
        tick(2);
        VB = 1'b0;
        tick(2);
        chk("zero_single_done", done_cnt, 1);

        // retrigger: three strobes during busy give exactly one more copy at next VB
        salt = 16'($urandom);
        pal_base    = 16'h0040;
        pal_page_en = 6'b000010;
        clr_stats();
        strobe_copy();
        model_copy(16'h0040, 6'b000010);
        VB = 1'b1;
        tick(10);
        VB = 1'b0;
        repeat (3) begin
            pal_copy = 1'b1;
            tick(1);
            pal_copy = 1'b0;
            tick(5);
        end
        wait_done("retrig_first");
        chk("retrig_first_drained", exp_q.size(), 0);
        chk("retrig_first_done", done_cnt, 1);
        clr_stats();
        tick(20);
        chk("retrig_not_immediate", busy_cyc, 0);
        model_copy(16'h0040, 6'b000010);
        vb_pulse();
        wait_done("retrig_second");
        chk("retrig_second_drained", exp_q.size(), 0);
        chk("retrig_second_writes", wr_cnt, 512);
        clr_stats();
        vb_pulse();
        tick(5);
        chk("retrig_collapsed", busy_cyc, 0);

        // slow memory with base/mask changed mid-copy
        salt = 16'($urandom);
        delay = 5;
        pal_base    = 16'h0100;
        pal_page_en = 6'b000001;
        clr_stats();
        strobe_copy();
        model_copy(16'h0100, 6'b000001);
        vb_pulse();
        tick(50);
        pal_base    = 16'hABCD;
        pal_page_en = 6'b111111;
        wait_done("slow");
        chk("slow_drained", exp_q.size(), 0);
        chk("slow_writes", wr_cnt, 512);
        chk("slow_done", done_cnt, 1);

        // reset mid-copy, with a copy re-armed just before the reset
        delay = 0;
        pal_base    = 16'h0200;
        pal_page_en = 6'b111111;
        clr_stats();
        strobe_copy();
        model_copy(16'h0200, 6'b111111);
        vb_pulse();
        k = 0;
        while (wr_cnt < 100 && k < 5000) begin
            tick(1);
            k++;
        end
        chk("rstmid_reached_100", 32'(wr_cnt >= 100), 1);
        pal_copy = 1'b1;
        tick(1);
        pal_copy = 1'b0;
        rst = 1'b1;
        tick(1);
        exp_q.delete();
        clr_stats();
        @(negedge clk);
        chk("rstmid_vram_req",  32'(bus.vram_req), 0);
        chk("rstmid_vram_addr", 32'(bus.vram_addr), 0);
        chk("rstmid_pal_we",    32'(bus.pal_we), 0);
        chk("rstmid_busy",      32'(busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick(1);
        vb_pulse();
        tick(10);
        chk("rstmid_no_writes", wr_cnt, 0);
        chk("rstmid_no_done", done_cnt, 0);
        chk("rstmid_no_restart", busy_cyc, 0);

        // randomized copies against the reference model
        stray_en = 1;
        for (int r = 0; r < 3; r++) begin
            salt = 16'($urandom);
            run_copy($sformatf("rand%0d", r), 16'($urandom),
                     6'($urandom_range(1, 63)), int'($urandom_range(0, 2)));
        end
        stray_en = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
